// File: rtl/byte_gather_n.sv
// byte_gather_n: collects 1, 2, 4 or 8 consecutive bytes (run-time mode,
// clipped to MAX_BYTES) into one right-aligned, big-endian word and offers
// it downstream with a valid/ready handshake. The output word is held
// under backpressure, and a synchronous flush drops any partial word.
module byte_gather_n #(
    parameter int MAX_BYTES = 4,
    parameter int CNT_W     = 3
) (
    input  logic                   clk8,
    input  logic                   rst,
    input  logic                   enb,
    input  logic                   flush,
    input  logic [1:0]             mode,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [8*MAX_BYTES-1:0] out_data,
    output logic [3:0]             out_bytes,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       byte_cnt
);

    localparam int W = 8 * MAX_BYTES;

    logic [W-1:0]     acc_reg;
    logic [W-1:0]     acc_shift;
    logic [W-1:0]     data_reg;
    logic [3:0]       bytes_reg;
    logic             valid_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       n_lat_reg;

    logic [3:0]       pow_mode;
    logic [3:0]       n_mode;
    logic [3:0]       n_eff;
    logic [4:0]       cnt_inc;
    logic             accept;
    logic             word_done;
    logic             out_take;

    // Only combinational path from out_ready: a free output slot, or one
    // being emptied this cycle, lets a byte in.
    assign in_ready = enb & (~valid_reg | out_ready);

    // A byte presented alongside flush is discarded.
    assign accept   = in_valid & in_ready & ~flush;
    assign out_take = valid_reg & out_ready & enb;

    // Word length: 2^mode clipped to MAX_BYTES; latched value applies mid-word.
    always_comb begin
        pow_mode  = 4'd1 << mode;
        n_mode    = (pow_mode > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : pow_mode;
        n_eff     = (cnt_reg == '0) ? n_mode : n_lat_reg;
        cnt_inc   = 5'(cnt_reg) + 5'd1;
        word_done = accept && (cnt_inc == {1'b0, n_eff});
    end

    // Shift the accumulator up one byte lane and insert the new byte at the
    // bottom; after N shifts of a cleared accumulator the first byte sits in
    // lane N-1, giving a right-aligned big-endian word with zero upper lanes.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_BYTES; gi++) begin : g_lane
            if (gi == 0) begin : g_low
                assign acc_shift[7:0] = in_data;
            end else begin : g_up
                assign acc_shift[8*gi +: 8] = acc_reg[8*(gi-1) +: 8];
            end
        end
    endgenerate

    // Gather state and output word; everything holds while enb is low.
    always_ff @(posedge clk8) begin
        if (rst) begin
            acc_reg   <= '0;
            data_reg  <= '0;
            bytes_reg <= 4'd1;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
            n_lat_reg <= 4'd1;
        end else if (enb) begin
            if (flush) begin
                cnt_reg <= '0;
                acc_reg <= '0;
            end else if (accept) begin
                if (cnt_reg == '0) begin
                    n_lat_reg <= n_mode;
                end
                if (word_done) begin
                    cnt_reg   <= '0;
                    acc_reg   <= '0;
                    data_reg  <= acc_shift;
                    bytes_reg <= n_eff;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    acc_reg <= acc_shift;
                end
            end
            // A completing word keeps out_valid high even if the old one
            // is taken in the same cycle.
            if (word_done) begin
                valid_reg <= 1'b1;
            end else if (out_take) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = data_reg;
    assign out_bytes = bytes_reg;
    assign out_valid = valid_reg;
    assign byte_cnt  = cnt_reg;

endmodule

// File: tb/tb_byte_gather_n.sv
// Testbench for byte_gather_n: directed scenarios plus randomized traffic,
// all checked against a transaction-level model built from a byte queue.
module tb_byte_gather_n;

    localparam int MAXB  = 4;
    localparam int CNT_W = 3;

    logic              clk8 = 1'b0;
    logic              rst = 1'b1;
    logic              enb = 1'b0;
    logic              flush = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [7:0]        in_data = 8'd0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [8*MAXB-1:0] out_data;
    logic [3:0]        out_bytes;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CNT_W-1:0]  byte_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    // Model state: bytes of the partial word, latched length, pending output.
    logic [7:0]  m_part[$];
    int          m_n = 1;
    bit          m_valid = 1'b0;
    logic [31:0] m_data = '0;
    logic [3:0]  m_bytes = 4'd1;
    bit          m_ready;

    logic [40:0] got;
    logic [40:0] exp;

    byte_gather_n #(.MAX_BYTES(MAXB), .CNT_W(CNT_W)) dut (
        .clk8(clk8), .rst(rst), .enb(enb), .flush(flush), .mode(mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_bytes(out_bytes), .out_valid(out_valid),
        .out_ready(out_ready), .byte_cnt(byte_cnt)
    );

    always #5 clk8 = ~clk8;

    // One clock: drive inputs, sample in_ready before the edge, advance the
    // model at the edge, then snapshot DUT and model at the falling edge.
    task automatic step(input bit r, input bit e, input bit f, input bit v,
                        input bit rd, input logic [1:0] m, input logic [7:0] d);
        bit      seen_ready;
        bit      hs;
        bit      done;
        longint  w;
        rst = r; enb = e; flush = f; in_valid = v; out_ready = rd;
        mode = m; in_data = d;
        #1;
        seen_ready = in_ready;
        m_ready = e && (!m_valid || rd);
        @(posedge clk8);
        if (r) begin
            m_part.delete();
            m_n = 1; m_valid = 1'b0; m_data = '0; m_bytes = 4'd1;
        end else if (e) begin
            hs = m_valid && rd;
            done = 1'b0;
            if (f) begin
                m_part.delete();
            end else if (v && m_ready) begin
                if (m_part.size() == 0)
                    m_n = ((2 ** int'(m)) > MAXB) ? MAXB : (2 ** int'(m));
                m_part.push_back(d);
                if (m_part.size() == m_n) begin
                    w = 0;
                    foreach (m_part[i]) w = w * 256 + longint'(m_part[i]);
                    m_data = w[31:0];
                    m_bytes = 4'(m_n);
                    done = 1'b1;
                    m_part.delete();
                end
            end
            if (done) m_valid = 1'b1;
            else if (hs) m_valid = 1'b0;
        end
        @(negedge clk8);
        got = {seen_ready, out_valid, out_bytes, byte_cnt, out_data};
        exp = {m_ready, m_valid, m_bytes, CNT_W'(m_part.size()), m_data};
    endtask

    task automatic test_reset();
        step(1, 1, 0, 0, 0, 2'd0, 8'h00);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", got, exp);
        end
        n_cmp++;
        if ({out_valid, out_bytes, byte_cnt, out_data} !== {1'b0, 4'd1, 3'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_const: got v=%0b b=%0d c=%0d d=%h want v=0 b=1 c=0 d=0",
                     out_valid, out_bytes, byte_cnt, out_data);
        end
        $display("reset: in_ready=%0b out_valid=%0b", got[40], out_valid);
    endtask

    task automatic test_basic();
        logic [7:0] b[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        step(1, 1, 0, 0, 1, 2'd2, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1, 1, 2'd2, b[i]);
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL basic[%0d]: got %h want %h", i, got, exp);
            end
            $display("basic byte %h: byte_cnt=%0d out_valid=%0b", b[i], byte_cnt, out_valid);
        end
        n_cmp++;
        if (out_data !== 32'hA1B2C3D4 || out_bytes !== 4'd4 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_word: got %h/%0d/%0b want a1b2c3d4/4/1", out_data, out_bytes, out_valid);
        end
        step(0, 1, 0, 0, 1, 2'd2, 8'h00);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL basic_drain: got %h want %h", got, exp);
        end
    endtask

    task automatic test_mode_clip();
        step(1, 1, 0, 0, 1, 2'd3, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 0, 1, 1, 2'd3, 8'(i));
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL clip[%0d]: got %h want %h", i, got, exp);
            end
            if (i == 4 || i == 8) $display("clip word: %h bytes=%0d", out_data, out_bytes);
        end
        n_cmp++;
        if (out_data !== 32'h05060708 || out_bytes !== 4'd4) begin
            n_fail++;
            $display("FAIL clip_word: got %h/%0d want 05060708/4", out_data, out_bytes);
        end
        step(0, 1, 0, 1, 1, 2'd0, 8'h5A);
        n_cmp++;
        if (got !== exp || out_data !== 32'h0000005A || out_bytes !== 4'd1) begin
            n_fail++;
            $display("FAIL single_byte: got %h want %h", got, exp);
        end
        $display("single byte word: %h bytes=%0d", out_data, out_bytes);
    endtask

    task automatic test_mode_latch();
        logic [7:0] b[4] = '{8'h33, 8'h44, 8'h55, 8'h66};
        step(1, 1, 0, 0, 1, 2'd1, 8'h00);
        step(0, 1, 0, 1, 1, 2'd1, 8'h11);
        step(0, 1, 0, 1, 1, 2'd2, 8'h22);
        n_cmp++;
        if (got !== exp || out_data !== 32'h00001122 || out_bytes !== 4'd2) begin
            n_fail++;
            $display("FAIL latch_word: got %h want %h", got, exp);
        end
        $display("latched word: %h bytes=%0d", out_data, out_bytes);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1, 1, 2'd2, b[i]);
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL latch_next[%0d]: got %h want %h", i, got, exp);
            end
        end
        n_cmp++;
        if (out_data !== 32'h33445566 || out_bytes !== 4'd4) begin
            n_fail++;
            $display("FAIL latch_next_word: got %h/%0d want 33445566/4", out_data, out_bytes);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] b[4] = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
        logic [7:0] c[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        step(1, 1, 0, 0, 0, 2'd2, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0, 2'd2, b[i]);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 1, 0, 2'd2, c[0]);
            n_cmp++;
            if (got !== exp || out_data !== 32'hCAFEBABE || got[40] !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: got %h want %h", i, got, exp);
            end
        end
        $display("backpressure: held %h, in_ready=%0b", out_data, got[40]);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1, 1, 2'd2, c[i]);
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL release[%0d]: got %h want %h", i, got, exp);
            end
        end
        n_cmp++;
        if (out_data !== 32'h11223344 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL release_word: got %h/%0b want 11223344/1", out_data, out_valid);
        end
    endtask

    task automatic test_flush();
        logic [7:0] b[4] = '{8'h40, 8'h50, 8'h60, 8'h70};
        step(1, 1, 0, 0, 1, 2'd2, 8'h00);
        step(0, 1, 0, 1, 1, 2'd2, 8'h10);
        step(0, 1, 0, 1, 1, 2'd2, 8'h20);
        step(0, 1, 1, 1, 1, 2'd2, 8'h30);
        n_cmp++;
        if (got !== exp || byte_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL flush: got %h want %h", got, exp);
        end
        $display("flush: byte_cnt=%0d", byte_cnt);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1, 1, 2'd2, b[i]);
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL post_flush[%0d]: got %h want %h", i, got, exp);
            end
        end
        n_cmp++;
        if (out_data !== 32'h40506070) begin
            n_fail++;
            $display("FAIL flush_word: got %h want 40506070", out_data);
        end
    endtask

    task automatic test_enable_reset();
        step(1, 1, 0, 0, 1, 2'd2, 8'h00);
        step(0, 1, 0, 1, 1, 2'd2, 8'h01);
        step(0, 1, 0, 1, 1, 2'd2, 8'h02);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 1, 2'd0, 8'hFF);
            n_cmp++;
            if (got !== exp || byte_cnt !== 3'd2) begin
                n_fail++;
                $display("FAIL freeze[%0d]: got %h want %h", i, got, exp);
            end
        end
        step(0, 1, 0, 1, 1, 2'd2, 8'h03);
        step(0, 1, 0, 1, 1, 2'd2, 8'h04);
        n_cmp++;
        if (got !== exp || out_data !== 32'h01020304) begin
            n_fail++;
            $display("FAIL freeze_word: got %h want %h", got, exp);
        end
        step(0, 1, 0, 1, 0, 2'd2, 8'h05);
        step(1, 1, 0, 1, 0, 2'd2, 8'h06);
        n_cmp++;
        if (got !== exp || {out_valid, out_bytes, byte_cnt, out_data} !== {1'b0, 4'd1, 3'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL mid_reset: got %h want %h", got, exp);
        end
        $display("mid-word reset: out_valid=%0b byte_cnt=%0d", out_valid, byte_cnt);
    endtask

    task automatic test_random();
        int bad = 0;
        step(1, 1, 0, 0, 1, 2'd0, 8'h00);
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)));
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                bad++;
                $display("FAIL random[%0d]: got %h want %h", i, got, exp);
            end
        end
        $display("random: 800 cycles, %0d bad", bad);
    endtask

    initial begin
        @(negedge clk8);
        test_reset();
        test_basic();
        test_mode_clip();
        test_mode_latch();
        test_backpressure();
        test_flush();
        test_enable_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
